// File: rtl/clkdiv_multi.sv
// clkdiv_multi: multi-channel tick generator.
// Each channel divides clk_100MHz by a runtime-reloadable divisor and produces
// a one-cycle enable pulse (tick) plus a square wave high for floor(D/2) of
// every D cycles. New divisors are staged in a shadow register and only take
// effect at the channel's terminal count, on sync_clr, or straight away when
// the channel is parked at divisor 0, so a period is never cut short or
// stretched. tick is meant to be used as a clock enable, never as a clock.
module clkdiv_multi #(
  parameter int unsigned NCH = 3,
  parameter int unsigned CW  = 32,
  parameter logic [NCH*CW-1:0] DIV_INIT = {32'd100_000, 32'd100_000_000, 32'd20_000_000},
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_100MHz,
  input  logic           rst_n,
  input  logic           en,
  input  logic           sync_clr,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] sq,
  output logic [NCH-1:0] pend
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam logic [CW-1:0] INIT = DIV_INIT[g*CW +: CW];

    logic [CW-1:0] cnt;
    logic [CW-1:0] div_act;
    logic [CW-1:0] div_sh;
    logic          tick_q;
    logic          sq_q;
    logic          pend_q;

    logic          wr_hit;
    logic          div_zero;
    logic [CW-1:0] div_m1;
    logic          at_term;
    logic [CW-1:0] cnt_next;
    logic          sq_next;

    // Decode the shared config strobe, and derive terminal count and the next
    // square-wave level from the divisor currently in force. div_m1 is forced
    // to zero for a parked channel so the subtraction never wraps.
    always_comb begin
      wr_hit   = cfg_we && (cfg_ch == CHW'(g));
      div_zero = (div_act == '0);
      div_m1   = div_zero ? '0 : (div_act - CW'(1));
      at_term  = !div_zero && (cnt == div_m1);
      cnt_next = at_term ? '0 : (cnt + CW'(1));
      sq_next  = (cnt_next < (div_act >> 1));
    end

    // Per-channel divider. sync_clr wins over everything; a parked channel
    // (divisor 0) pulls in the shadow on every edge so it can be woken up
    // even with en low. A write landing on the same edge as a reload is not
    // consumed by it: the old shadow is applied and the new one stays pending.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        div_act <= INIT;
        div_sh  <= INIT;
        tick_q  <= 1'b0;
        sq_q    <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        if (sync_clr || div_zero) begin
          cnt     <= '0;
          tick_q  <= 1'b0;
          sq_q    <= 1'b0;
          div_act <= div_sh;
          pend_q  <= 1'b0;
        end else if (en) begin
          cnt    <= cnt_next;
          tick_q <= at_term;
          sq_q   <= sq_next;
          if (at_term) begin
            div_act <= div_sh;
            pend_q  <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end

        if (wr_hit) begin
          div_sh <= cfg_div;
          pend_q <= 1'b1;
        end
      end
    end

    assign tick[g] = tick_q;
    assign sq[g]   = sq_q;
    assign pend[g] = pend_q;
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Testbench for clkdiv_multi with small divisors (ch0=1, ch1=5, ch2=4).
// A cycle-level reference model pushes the expected {tick,sq,pend} of every
// edge into a queue; each test pops and compares after the edge, and adds
// directed checks on tick positions, pending flags and async reset.
module tb_clkdiv_multi;

  logic        clk_100MHz = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sync_clr;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic [2:0]  tick;
  logic [2:0]  sq;
  logic [2:0]  pend;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [8:0] sb_q[$];
  logic [8:0] exp_v;

  localparam int unsigned INIT_DIV [3] = '{1, 5, 4};

  int unsigned m_cnt [3];
  int unsigned m_act [3];
  int unsigned m_sh  [3];
  bit          m_tick[3];
  bit          m_sq  [3];
  bit          m_pend[3];

  clkdiv_multi #(
    .NCH(3),
    .CW(32),
    .DIV_INIT({32'd4, 32'd5, 32'd1})
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst_n(rst_n),
    .en(en),
    .sync_clr(sync_clr),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .tick(tick),
    .sq(sq),
    .pend(pend)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_cnt[c]  = 0;
      m_act[c]  = INIT_DIV[c];
      m_sh[c]   = INIT_DIV[c];
      m_tick[c] = 1'b0;
      m_sq[c]   = 1'b0;
      m_pend[c] = 1'b0;
    end
  endtask

  // Advance the model by one edge using the inputs now applied, queue the
  // expected outputs, then let the DUT take the same edge.
  task automatic cycle();
    logic [8:0] e;
    e = '0;
    for (int c = 0; c < 3; c++) begin
      int unsigned nc, na;
      bit nt, ns, np;
      nc = m_cnt[c]; na = m_act[c]; nt = 1'b0; ns = m_sq[c]; np = m_pend[c];
      if (sync_clr || m_act[c] == 0) begin
        nc = 0; ns = 1'b0; na = m_sh[c]; np = 1'b0;
      end else if (en) begin
        nc = m_cnt[c] + 1;
        if (nc == m_act[c]) begin
          nc = 0; nt = 1'b1; na = m_sh[c]; np = 1'b0;
        end
        ns = (nc < m_act[c] / 2);
      end
      if (cfg_we && cfg_ch == c) begin
        m_sh[c] = cfg_div;
        np = 1'b1;
      end
      m_cnt[c] = nc; m_act[c] = na; m_tick[c] = nt; m_sq[c] = ns; m_pend[c] = np;
      e[6+c] = nt; e[3+c] = ns; e[c] = np;
    end
    sb_q.push_back(e);
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = '0;
    model_reset();
    repeat (2) @(negedge clk_100MHz);
    n_checks++;
    if (tick !== 3'b000) begin n_errors++; $display("FAIL reset_tick got=%b exp=000", tick); end
    n_checks++;
    if (sq !== 3'b000) begin n_errors++; $display("FAIL reset_sq got=%b exp=000", sq); end
    n_checks++;
    if (pend !== 3'b000) begin n_errors++; $display("FAIL reset_pend got=%b exp=000", pend); end
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_basic();
    en = 1'b1;
    while (cyc < 4) begin
      cycle();
      exp_v = sb_q.pop_front();
      n_checks++;
      if ({tick, sq, pend} !== exp_v) begin
        n_errors++; $display("FAIL basic_model cyc=%0d got=%b exp=%b", cyc, {tick, sq, pend}, exp_v);
      end
      n_checks++;
      if (tick[2] !== (cyc % 4 == 0)) begin
        n_errors++; $display("FAIL basic_tick2 cyc=%0d got=%b exp=%b", cyc, tick[2], cyc % 4 == 0);
      end
      n_checks++;
      if (sq[2] !== ((cyc % 4) < 2)) begin
        n_errors++; $display("FAIL basic_sq2 cyc=%0d got=%b exp=%b", cyc, sq[2], (cyc % 4) < 2);
      end
      n_checks++;
      if (tick[0] !== 1'b1 || sq[0] !== 1'b0) begin
        n_errors++; $display("FAIL basic_ch0 cyc=%0d got=%b%b exp=10", cyc, tick[0], sq[0]);
      end
    end
  endtask

  task automatic test_reload();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 32'd6;
    while (cyc < 24) begin
      cycle();
      cfg_we = 1'b0;
      exp_v = sb_q.pop_front();
      n_checks++;
      if ({tick, sq, pend} !== exp_v) begin
        n_errors++; $display("FAIL reload_model cyc=%0d got=%b exp=%b", cyc, {tick, sq, pend}, exp_v);
      end
      n_checks++;
      if (tick[2] !== (cyc == 8 || cyc == 14 || cyc == 20)) begin
        n_errors++; $display("FAIL reload_tick2 cyc=%0d got=%b", cyc, tick[2]);
      end
      n_checks++;
      if (pend[2] !== (cyc >= 5 && cyc < 8)) begin
        n_errors++; $display("FAIL reload_pend2 cyc=%0d got=%b", cyc, pend[2]);
      end
      n_checks++;
      if (tick[1] !== (cyc % 5 == 0)) begin
        n_errors++; $display("FAIL reload_tick1 cyc=%0d got=%b", cyc, tick[1]);
      end
    end
  endtask

  task automatic test_en_pause();
    logic [2:0] sq_hold;
    sq_hold = sq;
    en = 1'b0;
    repeat (3) begin
      cycle();
      exp_v = sb_q.pop_front();
      n_checks++;
      if ({tick, sq, pend} !== exp_v) begin
        n_errors++; $display("FAIL pause_model cyc=%0d got=%b exp=%b", cyc, {tick, sq, pend}, exp_v);
      end
      n_checks++;
      if (tick !== 3'b000 || sq !== sq_hold) begin
        n_errors++; $display("FAIL pause_hold cyc=%0d tick=%b sq=%b exp_tick=000 exp_sq=%b", cyc, tick, sq, sq_hold);
      end
    end
    en = 1'b1;
    while (cyc < 33) begin
      cycle();
      exp_v = sb_q.pop_front();
      n_checks++;
      if ({tick, sq, pend} !== exp_v) begin
        n_errors++; $display("FAIL resume_model cyc=%0d got=%b exp=%b", cyc, {tick, sq, pend}, exp_v);
      end
      n_checks++;
      if (tick[2] !== (cyc == 29)) begin
        n_errors++; $display("FAIL resume_tick2 cyc=%0d got=%b exp=%b", cyc, tick[2], cyc == 29);
      end
    end
  endtask

  task automatic test_sync_clr();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd7;
    cycle();
    cfg_we = 1'b0;
    exp_v = sb_q.pop_front();
    n_checks++;
    if ({tick, sq, pend} !== exp_v) begin
      n_errors++; $display("FAIL clr_pre_model cyc=%0d got=%b exp=%b", cyc, {tick, sq, pend}, exp_v);
    end
    n_checks++;
    if (pend[1] !== 1'b1) begin n_errors++; $display("FAIL clr_pre_pend1 got=%b exp=1", pend[1]); end
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    exp_v = sb_q.pop_front();
    n_checks++;
    if ({tick, sq, pend} !== exp_v) begin
      n_errors++; $display("FAIL clr_model cyc=%0d got=%b exp=%b", cyc, {tick, sq, pend}, exp_v);
    end
    n_checks++;
    if ({tick, sq, pend} !== 9'b0) begin
      n_errors++; $display("FAIL clr_outputs got=%b exp=000000000", {tick, sq, pend});
    end
    for (int k = 1; k <= 8; k++) begin
      cycle();
      exp_v = sb_q.pop_front();
      n_checks++;
      if ({tick, sq, pend} !== exp_v) begin
        n_errors++; $display("FAIL clr_post_model k=%0d got=%b exp=%b", k, {tick, sq, pend}, exp_v);
      end
      n_checks++;
      if (tick !== {k == 6, k == 7, 1'b1}) begin
        n_errors++; $display("FAIL clr_post_tick k=%0d got=%b exp=%b", k, tick, {k == 6, k == 7, 1'b1});
      end
    end
  endtask

  task automatic test_zero_div();
    bit seen;
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      cfg_we = 1'b0;
      exp_v = sb_q.pop_front();
      n_checks++;
      if ({tick, sq, pend} !== exp_v) begin
        n_errors++; $display("FAIL zero_wait_model cyc=%0d got=%b exp=%b", cyc, {tick, sq, pend}, exp_v);
      end
      if (tick[1]) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL zero_last_tick got=none exp=tick within 20 cycles"); end
    repeat (8) begin
      cycle();
      exp_v = sb_q.pop_front();
      n_checks++;
      if ({tick, sq, pend} !== exp_v) begin
        n_errors++; $display("FAIL zero_idle_model cyc=%0d got=%b exp=%b", cyc, {tick, sq, pend}, exp_v);
      end
      n_checks++;
      if (tick[1] !== 1'b0 || sq[1] !== 1'b0) begin
        n_errors++; $display("FAIL zero_silent cyc=%0d got=%b%b exp=00", cyc, tick[1], sq[1]);
      end
    end
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd3;
    cycle();
    cfg_we = 1'b0;
    exp_v = sb_q.pop_front();
    n_checks++;
    if (pend[1] !== 1'b1) begin n_errors++; $display("FAIL zero_wake_pend got=%b exp=1", pend[1]); end
    cycle();
    exp_v = sb_q.pop_front();
    n_checks++;
    if (pend[1] !== 1'b0) begin n_errors++; $display("FAIL zero_applied_pend got=%b exp=0", pend[1]); end
    for (int k = 1; k <= 7; k++) begin
      cycle();
      exp_v = sb_q.pop_front();
      n_checks++;
      if ({tick, sq, pend} !== exp_v) begin
        n_errors++; $display("FAIL wake_model k=%0d got=%b exp=%b", k, {tick, sq, pend}, exp_v);
      end
      n_checks++;
      if (tick[1] !== (k == 3 || k == 6)) begin
        n_errors++; $display("FAIL wake_tick1 k=%0d got=%b exp=%b", k, tick[1], k == 3 || k == 6);
      end
    end
  endtask

  task automatic test_async_reset();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 32'd9;
    cycle();
    cfg_we = 1'b0;
    exp_v = sb_q.pop_front();
    n_checks++;
    if (pend[2] !== 1'b1 || tick[0] !== 1'b1) begin
      n_errors++; $display("FAIL arst_pre pend2=%b tick0=%b exp=1 1", pend[2], tick[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tick, sq, pend} !== 9'b0) begin
      n_errors++; $display("FAIL arst_immediate got=%b exp=000000000", {tick, sq, pend});
    end
    model_reset();
    @(negedge clk_100MHz);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 12) begin
      cycle();
      exp_v = sb_q.pop_front();
      n_checks++;
      if ({tick, sq, pend} !== exp_v) begin
        n_errors++; $display("FAIL arst_model cyc=%0d got=%b exp=%b", cyc, {tick, sq, pend}, exp_v);
      end
      n_checks++;
      if (tick[2] !== (cyc % 4 == 0) || tick[1] !== (cyc % 5 == 0)) begin
        n_errors++; $display("FAIL arst_div_init cyc=%0d got=%b exp=%b%b", cyc, tick[2:1], cyc % 4 == 0, cyc % 5 == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_en_pause();
    test_sync_clr();
    test_zero_div();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
